decoder8b10b_sync_ctrl: RTL and testbench

//  Word-alignment and link-sync controller in front of the 8b/10b decoder path.
//  - Takes raw, unaligned 10-bit deserializer words and finds the comma.
//  - Locks a bit offset and delivers aligned 10b words to the decoder.
//  - Runs a comma/error-driven sync FSM that uses the decoder's code-error flag to declare
//    or drop link sync.

---
 rtl/decoder8b10b_sync_ctrl_pkg.sv | 19 +
 rtl/decoder8b10b_comma_find.sv | 31 +++
 rtl/decoder8b10b_sync_ctrl.sv | 162 ++++++++++++++++
 tb/tb_decoder8b10b_sync_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder8b10b_sync_ctrl_pkg.sv
// Shared constants for the 8b/10b word-alignment and link-sync controller.
// Holds the sync FSM state codes, the comma lead patterns and the alignment width.
package decoder8b10b_sync_ctrl_pkg;

    localparam int ALIGN_W = 10;

    localparam logic [1:0] LOS   = 2'd0;
    localparam logic [1:0] COMMA = 2'd1;
    localparam logic [1:0] SYNC  = 2'd2;

    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

    // s[6] is the earliest bit of the 7-bit lead
    function automatic logic is_comma(input logic [6:0] s);
        return (s == COMMA_P) || (s == COMMA_N);
    endfunction

endpackage

// File: rtl/decoder8b10b_comma_find.sv
// Combinational comma search over the 20-bit history at every bit offset 0..9.
// Reports the per-offset hit vector, any-hit, and the lowest hitting offset.
module decoder8b10b_comma_find
    import decoder8b10b_sync_ctrl_pkg::*;
(
    input  logic [19:0] hist,
    output logic        hit,
    output logic [3:0]  k,
    output logic [9:0]  hit_vec
);

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < ALIGN_W; i++) begin
            hit_vec[i] = is_comma(hist[19-i -: 7]);
        end
    end

    // Scan from the top so the lowest offset is the one left in k
    always_comb begin
        k = '0;
        for (int i = ALIGN_W - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                k = 4'(i);
            end
        end
    end

    assign hit = |hit_vec;

endmodule

// File: rtl/decoder8b10b_sync_ctrl.sv
// Word aligner and link-sync FSM in front of the 8b/10b decoder.
// Locks a bit offset on a comma while in LOS, then tracks sync from commas and decoder errors.
//
// state | meaning
// LOS   | no lock; any comma at any offset realigns
// COMMA | offset locked, counting aligned commas towards sync
// SYNC  | link in sync; code errors counted, good runs forgive them
module decoder8b10b_sync_ctrl
    import decoder8b10b_sync_ctrl_pkg::*;
#(
    parameter int COMMAS_TO_SYNC = 3,
    parameter int GOOD_RUN       = 4,
    parameter int MAX_ERRS       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [9:0] i_raw10,
    input  logic       i_code_err,
    output logic       o_valid,
    output logic [9:0] o_data10,
    output logic       o_comma,
    output logic [3:0] o_offset,
    output logic       o_realign,
    output logic       o_sync
);

    localparam int CW = $clog2(COMMAS_TO_SYNC + 1);
    localparam int EW = $clog2(MAX_ERRS + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);

    logic [9:0]    prev_raw;
    logic [19:0]   hist;
    logic          hit;
    logic [3:0]    k;
    logic [9:0]    hit_vec;
    logic          realign;
    logic          comma_now;
    logic [3:0]    sel_k;
    logic [9:0]    window;
    logic [9:0]    aligned;

    logic [1:0]    state, state_nx;
    logic [CW-1:0] commas, commas_nx;
    logic [EW-1:0] errs, errs_nx;
    logic [GW-1:0] good, good_nx;

    assign hist = {prev_raw, i_raw10};

    decoder8b10b_comma_find u_comma_find (
        .hist    (hist),
        .hit     (hit),
        .k       (k),
        .hit_vec (hit_vec)
    );

    // Once locked, only the locked offset can produce a comma
    assign realign   = (state == LOS) && hit;
    assign comma_now = realign || hit_vec[o_offset];
    assign sel_k     = realign ? k : o_offset;

    always_comb begin
        window = '0;
        for (int i = 0; i < ALIGN_W; i++) begin
            if (sel_k == 4'(i)) begin
                window = hist[19-i -: 10];
            end
        end
    end

    // window[9] is s0; decoder wants {s6..s9, s0..s5}
    assign aligned = {window[3:0], window[9:4]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_raw  <= '0;
            o_valid   <= 1'b0;
            o_data10  <= '0;
            o_comma   <= 1'b0;
            o_offset  <= '0;
            o_realign <= 1'b0;
        end else begin
            o_valid   <= i_valid;
            o_realign <= i_valid && realign;
            if (i_valid) begin
                prev_raw <= i_raw10;
                o_data10 <= aligned;
                o_comma  <= comma_now;
                if (realign) begin
                    o_offset <= k;
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        commas_nx = commas;
        errs_nx   = errs;
        good_nx   = good;
        if (o_valid) begin
            case (state)
                LOS: begin
                    if (o_comma) begin
                        state_nx  = COMMA;
                        commas_nx = CW'(1);
                    end
                end
                COMMA: begin
                    if (i_code_err) begin
                        state_nx  = LOS;
                        commas_nx = '0;
                    end else if (o_comma) begin
                        commas_nx = commas + 1'b1;
                        if (commas == CW'(COMMAS_TO_SYNC - 1)) begin
                            state_nx = SYNC;
                            errs_nx  = '0;
                            good_nx  = '0;
                        end
                    end
                end
                SYNC: begin
                    if (i_code_err) begin
                        errs_nx = errs + 1'b1;
                        good_nx = '0;
                        if (errs == EW'(MAX_ERRS - 1)) begin
                            state_nx = LOS;
                        end
                    end else if (good == GW'(GOOD_RUN - 1)) begin
                        // good-run counter parks here while there is nothing to forgive
                        if (errs != '0) begin
                            errs_nx = errs - 1'b1;
                            good_nx = '0;
                        end
                    end else begin
                        good_nx = good + 1'b1;
                    end
                end
                default: begin
                    state_nx = LOS;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= LOS;
            commas <= '0;
            errs   <= '0;
            good   <= '0;
            o_sync <= 1'b0;
        end else begin
            state  <= state_nx;
            commas <= commas_nx;
            errs   <= errs_nx;
            good   <= good_nx;
            o_sync <= (state_nx == SYNC);
        end
    end

endmodule

// File: tb/tb_decoder8b10b_sync_ctrl.sv
// Directed bench for the 8b/10b aligner/sync controller with hand-computed expectations.
// Each step drives one cycle, then samples outputs 1 ns after the rising edge.
module tb_decoder8b10b_sync_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [9:0] i_raw10 = '0;
    logic       i_code_err = 1'b0;
    logic       o_valid;
    logic [9:0] o_data10;
    logic       o_comma;
    logic [3:0] o_offset;
    logic       o_realign;
    logic       o_sync;

    int checks = 0;
    int errors = 0;

    // K28.5 RD- at offset 0, and the same bit stream slipped by 7, 3 and 5 bits
    localparam logic [9:0] W_A  = 10'b0011111010;
    localparam logic [9:0] W_R7 = 10'b1111010001;
    localparam logic [9:0] W_R3 = 10'b0100011111;
    localparam logic [9:0] W_R5 = 10'b1101000111;
    localparam logic [9:0] W_F  = 10'b0101010101;
    localparam logic [9:0] W_AL = 10'b1010001111;

    int pat4 [13] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1};
    int pat3 [6]  = '{1, 0, 1, 0, 0, 1};

    decoder8b10b_sync_ctrl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_raw10    (i_raw10),
        .i_code_err (i_code_err),
        .o_valid    (o_valid),
        .o_data10   (o_data10),
        .o_comma    (o_comma),
        .o_offset   (o_offset),
        .o_realign  (o_realign),
        .o_sync     (o_sync)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // err applies to the word already on o_data10 before this edge
    task automatic cyc(input logic v, input logic [9:0] raw, input logic err);
        i_valid    = v;
        i_raw10    = raw;
        i_code_err = err;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [9:0] raw);
        i_rst      = 1'b1;
        i_valid    = v;
        i_raw10    = raw;
        i_code_err = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   32'(o_valid),   0);
        chk({tag, "_data"},    32'(o_data10),  0);
        chk({tag, "_comma"},   32'(o_comma),   0);
        chk({tag, "_offset"},  32'(o_offset),  0);
        chk({tag, "_realign"}, 32'(o_realign), 0);
        chk({tag, "_sync"},    32'(o_sync),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: offset-0 comma stream from reset
        do_reset(1'b0, '0);
        do_reset(1'b0, '0);
        chk_all_zero("rst");
        cyc(1'b1, W_A, 1'b0);
        chk("t1_w1_valid",   32'(o_valid),   1);
        chk("t1_w1_comma",   32'(o_comma),   0);
        chk("t1_w1_realign", 32'(o_realign), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t1_w2_realign", 32'(o_realign), 1);
        chk("t1_w2_offset",  32'(o_offset),  0);
        chk("t1_w2_comma",   32'(o_comma),   1);
        chk("t1_w2_data",    32'(o_data10),  32'(W_AL));
        cyc(1'b1, W_A, 1'b0);
        chk("t1_w3_sync", 32'(o_sync), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t1_w4_sync", 32'(o_sync), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t1_w5_sync", 32'(o_sync), 1);

        // 4: errors interleaved with good runs never reach MAX_ERRS
        for (int i = 0; i < 13; i++) begin
            cyc(1'b1, W_A, pat4[i] != 0);
            chk("t4_sync", 32'(o_sync), 1);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, W_F, 1'b0);
        end
        chk("t4_sync_after_goods", 32'(o_sync), 1);

        // 3: four closely spaced errors drop sync, then relock at offset 3
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, W_F, pat3[i] != 0);
            chk("t3_sync_hold", 32'(o_sync), 1);
        end
        cyc(1'b1, W_F, 1'b1);
        chk("t3_sync_drop", 32'(o_sync), 0);
        cyc(1'b0, W_F, 1'b0);
        chk("t3_gap_valid", 32'(o_valid), 0);
        cyc(1'b1, W_R3, 1'b0);
        chk("t3_r1_realign", 32'(o_realign), 0);
        cyc(1'b1, W_R3, 1'b0);
        chk("t3_r2_realign", 32'(o_realign), 1);
        chk("t3_r2_offset",  32'(o_offset),  3);
        chk("t3_r2_comma",   32'(o_comma),   1);
        chk("t3_r2_data",    32'(o_data10),  32'(W_AL));

        // 2: offset-7 stream
        do_reset(1'b0, '0);
        cyc(1'b1, W_R7, 1'b0);
        chk("t2_w1_realign", 32'(o_realign), 0);
        cyc(1'b1, W_R7, 1'b0);
        chk("t2_w2_realign", 32'(o_realign), 1);
        chk("t2_w2_offset",  32'(o_offset),  7);
        chk("t2_w2_comma",   32'(o_comma),   1);
        chk("t2_w2_data",    32'(o_data10),  32'(W_AL));
        cyc(1'b1, W_R7, 1'b0);
        chk("t2_w3_offset", 32'(o_offset), 7);
        chk("t2_w3_data",   32'(o_data10), 32'(W_AL));

        // 5: foreign-offset comma ignored in COMMA; err with comma returns to LOS
        do_reset(1'b0, '0);
        cyc(1'b1, W_A, 1'b0);
        cyc(1'b1, W_A, 1'b0);
        chk("t5_w2_comma", 32'(o_comma), 1);
        cyc(1'b1, W_R5, 1'b0);
        chk("t5_w3_comma",   32'(o_comma),   1);
        chk("t5_w3_realign", 32'(o_realign), 1);
        cyc(1'b1, W_R5, 1'b0);
        chk("t5_off5_realign", 32'(o_realign), 0);
        chk("t5_off5_offset",  32'(o_offset),  0);
        chk("t5_off5_comma",   32'(o_comma),   0);
        cyc(1'b1, W_A, 1'b0);
        chk("t5_w5_comma", 32'(o_comma), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t5_w6_comma",   32'(o_comma),   1);
        chk("t5_w6_realign", 32'(o_realign), 0);
        cyc(1'b1, W_A, 1'b1);
        chk("t5_err_sync", 32'(o_sync), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t5_los_realign", 32'(o_realign), 1);
        chk("t5_los_sync",    32'(o_sync),    0);

        // 6: valid gaps hold everything; reset in SYNC clears all
        do_reset(1'b0, '0);
        cyc(1'b1, W_A, 1'b0);
        cyc(1'b0, W_A, 1'b0);
        chk("t6_gap1_valid", 32'(o_valid), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t6_w2_comma",   32'(o_comma),   1);
        chk("t6_w2_realign", 32'(o_realign), 1);
        cyc(1'b0, '0, 1'b0);
        chk("t6_gap2_valid",   32'(o_valid),   0);
        chk("t6_gap2_data",    32'(o_data10),  32'(W_AL));
        chk("t6_gap2_realign", 32'(o_realign), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t6_w3_comma", 32'(o_comma), 1);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b1, W_A, 1'b0);
        chk("t6_w4_sync", 32'(o_sync), 0);
        cyc(1'b0, '0, 1'b0);
        chk("t6_gap4_sync",  32'(o_sync),  1);
        chk("t6_gap4_valid", 32'(o_valid), 0);
        do_reset(1'b1, W_A);
        chk_all_zero("t6_rst");
        cyc(1'b1, W_A, 1'b0);
        chk("t6_post_rst_comma",   32'(o_comma),   0);
        chk("t6_post_rst_realign", 32'(o_realign), 0);
        cyc(1'b1, W_A, 1'b0);
        chk("t6_post_rst_w2_realign", 32'(o_realign), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
